// File: rtl/ps2_pkg.sv
// PS/2 scan-code constants, decoder state encoding
// and 7-segment glyph table shared by the key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } ps2_state_e;

  // Glyphs are {a,b,c,d,e,f,g,dp}, active-high.
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;
  localparam logic [7:0] SEG_A = 8'hEE;
  localparam logic [7:0] SEG_B = 8'h3E;
  localparam logic [7:0] SEG_C = 8'h9C;
  localparam logic [7:0] SEG_D = 8'h7A;
  localparam logic [7:0] SEG_E = 8'h9E;
  localparam logic [7:0] SEG_F = 8'h8E;

  function automatic logic [7:0] seg_glyph(
    input logic [3:0] v
  );
    logic [7:0] g;
    unique case (v)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// One 7-segment digit: hex glyph with blank
// and decimal-point control, optional inversion.
module seg7_hex
  import ps2_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] raw;

  // Blank overrides both glyph and dp.
  always_comb begin
    raw = SEG_BLANK;
    if (!blank) begin
      raw = seg_glyph(value) | {7'b0, dp};
    end
    seg = SEG_ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops PS/2 scan codes, tracks the held key,
// counts presses in BCD and drives the displays.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int CNT_DIGITS     = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SHOW_EXT_DP    = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [7:0]              ps2_data_in,
  input  logic                    ps2_ready,
  input  logic                    ps2_overflow,
  output logic                    nextdata_n,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic                    key_held,
  output logic [4*CNT_DIGITS-1:0] press_cnt,
  output logic                    err_sticky,
  output logic [15:0]             seg_code,
  output logic [8*CNT_DIGITS-1:0] seg_cnt
);

  localparam int CW = 4 * CNT_DIGITS;

  ps2_state_e      state_q;
  ps2_state_e      state_d;
  logic            accept;
  logic            do_make;
  logic            do_break;
  logic            ext_bit;
  logic            same_key;
  logic [CW-1:0]   cnt_inc;

  // No sampling while the pop strobe is low.
  assign accept = ps2_ready & nextdata_n;

  assign same_key = key_held
                  && (key_ext == ext_bit)
                  && (key_code == ps2_data_in);

  // Prefix decoder: next state and make/break events.
  always_comb begin
    state_d  = state_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    ext_bit  = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_data_in == PS2_EXT) begin
            state_d = ST_E0;
          end else if (ps2_data_in == PS2_BRK) begin
            state_d = ST_F0;
          end else if (ps2_data_in != PS2_PAUSE) begin
            do_make = 1'b1;
          end
        end
        ST_E0: begin
          ext_bit = 1'b1;
          if (ps2_data_in == PS2_BRK) begin
            state_d = ST_E0F0;
          end else if (ps2_data_in == PS2_EXT) begin
            state_d = ST_E0;
          end else begin
            do_make = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_F0: begin
          state_d = ST_IDLE;
          if (ps2_data_in != PS2_EXT
              && ps2_data_in != PS2_BRK) begin
            do_break = 1'b1;
          end
        end
        ST_E0F0: begin
          ext_bit = 1'b1;
          state_d = ST_IDLE;
          if (ps2_data_in != PS2_EXT
              && ps2_data_in != PS2_BRK) begin
            do_break = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // BCD ripple increment, all-nines wraps to zero.
  always_comb begin
    logic       c;
    logic [3:0] d;
    cnt_inc = press_cnt;
    c = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      d = press_cnt[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pop strobe, held-key tracking, counter, error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      nextdata_n <= 1'b1;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_held   <= 1'b0;
      press_cnt  <= '0;
      err_sticky <= 1'b0;
    end else begin
      nextdata_n <= ~accept;
      if (ps2_overflow) begin
        err_sticky <= 1'b1;
      end
      if (do_make && !same_key) begin
        key_code  <= ps2_data_in;
        key_ext   <= ext_bit;
        key_held  <= 1'b1;
        press_cnt <= cnt_inc;
      end
      if (do_break && same_key) begin
        key_held <= 1'b0;
      end
    end
  end

  seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_code_hi (
    .value (key_code[7:4]),
    .blank (~key_held),
    .dp    (SHOW_EXT_DP & key_ext),
    .seg   (seg_code[15:8])
  );

  seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_code_lo (
    .value (key_code[3:0]),
    .blank (~key_held),
    .dp    (1'b0),
    .seg   (seg_code[7:0])
  );

  for (genvar g = 0; g < CNT_DIGITS; g++) begin : g_cnt
    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_cnt (
      .value (press_cnt[4*g +: 4]),
      .blank (1'b0),
      .dp    (1'b0),
      .seg   (seg_cnt[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized and directed bench for ps2_key_tracker
// against a prefix-flag reference model.
module tb_ps2_key_tracker;

  localparam int ND  = 2;
  localparam int LIM = 100;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [7:0]      ps2_data_in = 8'h00;
  logic            ps2_ready = 1'b0;
  logic            ps2_overflow = 1'b0;
  logic            nextdata_n;
  logic [7:0]      key_code;
  logic            key_ext;
  logic            key_held;
  logic [4*ND-1:0] press_cnt;
  logic            err_sticky;
  logic [15:0]     seg_code;
  logic [8*ND-1:0] seg_cnt;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .CNT_DIGITS(ND),
    .SEG_ACTIVE_LOW(1'b1),
    .SHOW_EXT_DP(1'b1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2_data_in  (ps2_data_in),
    .ps2_ready    (ps2_ready),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_held     (key_held),
    .press_cnt    (press_cnt),
    .err_sticky   (err_sticky),
    .seg_code     (seg_code),
    .seg_cnt      (seg_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference glyphs, active-high {a..g,dp}.
  logic [7:0] hex_tab [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  function automatic logic [7:0] seg_of(
    input logic [3:0] v, input bit blank, input bit dp
  );
    logic [7:0] r;
    r = blank ? 8'h00 : (hex_tab[v] | {7'b0, dp});
    return ~r;
  endfunction

  function automatic logic [4*ND-1:0] bcd_of(input int n);
    logic [4*ND-1:0] r;
    int x;
    x = n;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [8*ND-1:0] segcnt_of(input int n);
    logic [8*ND-1:0] r;
    logic [4*ND-1:0] b;
    b = bcd_of(n);
    for (int i = 0; i < ND; i++) begin
      r[8*i +: 8] = seg_of(b[4*i +: 4], 1'b0, 1'b0);
    end
    return r;
  endfunction

  // Model: pending prefix flags plus held-key record.
  bit         m_pext, m_pbrk, m_ext, m_held;
  logic [7:0] m_code;
  int         m_cnt;

  task automatic m_clear();
    m_pext = 0; m_pbrk = 0; m_ext = 0; m_held = 0;
    m_code = 8'h00; m_cnt = 0;
  endtask

  task automatic m_apply(input logic [7:0] b);
    bit same;
    same = m_held && (m_ext == m_pext) && (m_code == b);
    if (m_pbrk) begin
      if (b != 8'hE0 && b != 8'hF0 && same) m_held = 0;
      m_pbrk = 0;
      m_pext = 0;
    end else if (b == 8'hF0) begin
      m_pbrk = 1;
    end else if (b == 8'hE0) begin
      m_pext = 1;
    end else if (b == 8'hE1 && !m_pext) begin
      m_pext = 0;
    end else begin
      if (!same) begin
        m_code = b;
        m_ext  = m_pext;
        m_held = 1;
        m_cnt  = (m_cnt + 1) % LIM;
      end
      m_pext = 0;
    end
  endtask

  logic [7:0] q[$];
  bit  gap_en = 0;
  bit  prev_low = 0;
  int  cyc = 0;
  int  last_pop = -1;
  int  npops = 0;

  // Source FIFO, pop tracking and per-byte comparison.
  always @(negedge clk) begin
    logic [7:0] b;
    bit stall;
    cyc++;
    if (!resetn) begin
      m_clear();
      prev_low  = 0;
      last_pop  = -1;
      ps2_ready = 1'b0;
    end else begin
      if (!nextdata_n) begin
        npops++;
        chk("pulse_width", {31'b0, prev_low}, 0);
        chk("pop_has_byte", {31'b0, q.size() > 0}, 1);
        if (q.size() > 0) begin
          b = q.pop_front();
          m_apply(b);
          if (!gap_en && last_pop >= 0)
            chk("accept_gap", cyc - last_pop, 2);
          last_pop = cyc;
          chk("key_code", {24'b0, key_code}, {24'b0, m_code});
          chk("key_ext", {31'b0, key_ext}, {31'b0, m_ext});
          chk("key_held", {31'b0, key_held}, {31'b0, m_held});
          chk("press_cnt", 32'(press_cnt), 32'(bcd_of(m_cnt)));
          chk("seg_code", {16'b0, seg_code},
              {16'b0, seg_of(m_code[7:4], !m_held, m_ext),
               seg_of(m_code[3:0], !m_held, 1'b0)});
          chk("seg_cnt", 32'(seg_cnt), 32'(segcnt_of(m_cnt)));
        end
      end
      if (q.size() == 0 && nextdata_n) last_pop = -1;
      prev_low = !nextdata_n;
      stall = gap_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      ps2_ready = (q.size() > 0) && !stall;
      if (q.size() > 0) ps2_data_in = q[0];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || !nextdata_n) && n < 5000) begin
      tick();
      n++;
    end
    tick();
    chk("drain_in_time", {31'b0, n < 5000}, 1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_ndn", {31'b0, nextdata_n}, 1);
    chk("rst_code", {24'b0, key_code}, 0);
    chk("rst_ext", {31'b0, key_ext}, 0);
    chk("rst_held", {31'b0, key_held}, 0);
    chk("rst_cnt", 32'(press_cnt), 0);
    chk("rst_err", {31'b0, err_sticky}, 0);
    chk("rst_seg_code", {16'b0, seg_code}, 32'hFFFF);
    chk("rst_seg_cnt", 32'(seg_cnt), 32'(segcnt_of(0)));
    #2;
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    int p0;
    logic [7:0] pool [6];
    pool = '{8'h1C, 8'h23, 8'h75, 8'h15, 8'h6B, 8'h74};
    m_clear();
    do_reset();

    p0 = npops;
    q.push_back(8'h1C);
    drain();
    chk("t1_seg_make", {16'b0, seg_code},
        {16'b0, ~8'h60, ~8'h9C});
    q.push_back(8'hF0);
    q.push_back(8'h1C);
    drain();
    chk("t1_seg_blank", {16'b0, seg_code}, 32'hFFFF);
    chk("t1_pops", npops - p0, 3);

    for (int i = 0; i < 5; i++) q.push_back(8'h23);
    drain();
    chk("t2_cnt_typematic", 32'(press_cnt), 32'h02);
    q.push_back(8'hF0);
    q.push_back(8'h23);
    drain();
    chk("t2_held_after_brk", {31'b0, key_held}, 0);

    q.push_back(8'hE0);
    q.push_back(8'h75);
    drain();
    chk("t3_dp_lit", {31'b0, seg_code[8]}, 0);
    q.push_back(8'hF0);
    q.push_back(8'h75);
    drain();
    chk("t3_plain_brk_ign", {31'b0, key_held}, 1);
    q.push_back(8'hE0);
    q.push_back(8'hF0);
    q.push_back(8'h75);
    drain();
    chk("t3_ext_brk", {31'b0, key_held}, 0);

    do_reset();
    for (int i = 0; i < 100; i++)
      q.push_back(i[0] ? 8'h23 : 8'h15);
    drain();
    chk("t4_wrap_cnt", 32'(press_cnt), 0);
    chk("t4_wrap_seg", 32'(seg_cnt), 32'(segcnt_of(0)));

    ps2_overflow = 1'b1;
    tick();
    ps2_overflow = 1'b0;
    chk("t5_err_set", {31'b0, err_sticky}, 1);
    repeat (5) tick();
    chk("t5_err_hold", {31'b0, err_sticky}, 1);

    q.push_back(8'hE0);
    q.push_back(8'hF0);
    drain();
    do_reset();
    q.push_back(8'h1C);
    drain();
    chk("t6_code", {24'b0, key_code}, 32'h1C);
    chk("t6_ext", {31'b0, key_ext}, 0);
    chk("t6_cnt", 32'(press_cnt), 1);

    gap_en = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) q.push_back(8'hE0);
      else if (r <= 2) q.push_back(8'hF0);
      else if (r == 3) q.push_back(8'hE1);
      else if (r == 4) q.push_back(8'($urandom_range(0, 255)));
      else q.push_back(pool[$urandom_range(0, 5)]);
    end
    drain();
    gap_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Consumes scan-code bytes from the ps2_keyboard receiver through its ready/nextdata_n pop handshake.
- Decodes make, break and E0-extended sequences, and tracks the currently held key.
- Counts distinct key presses in BCD, ignoring typematic repeats.
- Drives a hex display of the held key and a decimal display of the press count on the board's 7-segment digits.
- Replaces the ad-hoc keyboard/display glue in the top level.

Parameters:
- CNT_DIGITS, 2, number of BCD digits in the press counter and count display (1..4).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (board LEDs light on 0); 0 = active-high.
- SHOW_EXT_DP, 1, 1 = light the dp of the high key-code digit while the held key is E0-extended.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- ps2_data_in  in  8  head byte of ps2_keyboard FIFO.
- ps2_ready  in  1  FIFO non-empty.
- ps2_overflow  in  1  FIFO overflow flag from ps2_keyboard.
- nextdata_n  out  1  pop strobe, active-low, one cycle.
- key_code  out  8  scan code of held key (last make).
- key_ext  out  1  held key was E0-prefixed.
- key_held  out  1  a key is currently held.
- press_cnt  out  4*CNT_DIGITS  BCD press count, digit 0 in LSBs.
- err_sticky  out  1  ps2_overflow was seen since reset.
- seg_code  out  16  two digits {hi,lo}: hex of key_code, blank when !key_held.
- seg_cnt  out  8*CNT_DIGITS  decimal digits of press_cnt, digit 0 in LSBs.

Behaviour:
- Reset values (asynchronous, resetn=0):
  - nextdata_n=1, key_code=0, key_ext=0, key_held=0, press_cnt=0, err_sticky=0, FSM=IDLE.
  - seg_code shows blank; seg_cnt shows all zeros.
- Reset asserted mid-sequence discards any pending prefix.
- Handshake:
  - A byte is accepted on a clock edge where ps2_ready=1 and nextdata_n=1.
  - On that edge nextdata_n goes to 0 for exactly one cycle, then returns to 1.
  - Throughput is at most one byte per 2 cycles; ps2_ready is never sampled while nextdata_n=0.
- FSM states: IDLE, E0, F0, E0F0.
  - IDLE: 0xE0 -> E0; 0xF0 -> F0; 0xE1 -> IDLE (ignored, Pause unsupported); other byte b -> MAKE(b, ext=0).
  - E0: 0xF0 -> E0F0; 0xE0 -> E0; other b -> MAKE(b, ext=1), go to IDLE.
  - F0: 0xE0/0xF0 -> IDLE (malformed, dropped); other b -> BREAK(b, ext=0), go to IDLE.
  - E0F0: other b -> BREAK(b, ext=1), go to IDLE; 0xE0/0xF0 -> IDLE.
- MAKE(b,x):
  - If key_held and {key_ext,key_code}=={x,b}, it is a typematic repeat: no change.
  - Otherwise: key_code<=b, key_ext<=x, key_held<=1, press_cnt<=press_cnt+1.
- BREAK(b,x):
  - If key_held and {key_ext,key_code}=={x,b}, then key_held<=0; key_code and key_ext are retained.
  - Otherwise it is ignored.
- Press counter:
  - BCD ripple increment; each digit wraps 9->0 and carries into the next.
  - All-nines wraps to all zeros; no saturation.
- Latency: registered outputs update on the accept edge, visible in the following cycle. Segment outputs are combinational from registered state, so there is no extra delay.
- err_sticky is set on any cycle with ps2_overflow=1 and is cleared only by reset.
- Segment encoding:
  - Bit order {a,b,c,d,e,f,g,dp}. Digit patterns are active-high before the SEG_ACTIVE_LOW inversion; hex A..F use standard forms (A,b,C,d,E,F).
  - Blank = all segments off.
  - dp is off except as defined by SHOW_EXT_DP.

Decomposition:
- Package ps2_pkg: constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1; FSM state encoding; segment pattern constants for 0..F and blank.
- One sub-module, seg7_hex: 4-bit value, blank, dp in; 8-bit segment out; parameter SEG_ACTIVE_LOW. Instantiated 2+CNT_DIGITS times.

Test Plan:
- Reset then feed 0x1C, 0xF0, 0x1C -> after the make: key_code=0x1C, key_held=1, press_cnt=1, seg_code="1C"; after the break: key_held=0, seg_code blank; nextdata_n pulses low exactly 3 times, one cycle each.
- Feed 0x23 five times (typematic) then 0xF0, 0x23 -> press_cnt=1 throughout; key_held drops only after the break.
- Feed 0xE0, 0x75 -> key_code=0x75, key_ext=1, high-digit dp lit. Then feed 0xF0, 0x75 (non-extended break) -> ignored, key_held stays 1. Then feed 0xE0, 0xF0, 0x75 -> key_held=0.
- With CNT_DIGITS=2, issue 100 distinct presses (alternating 0x15 and 0x23) -> press_cnt goes 0x99 then wraps to 0x00; seg_cnt shows "00".
- Keep ps2_ready=1 continuously -> exactly one accept per 2 cycles. Pulse ps2_overflow for one cycle -> err_sticky=1 and stays set until resetn=0.
- Deassert resetn after 0xE0, 0xF0 have been accepted, then feed 0x1C -> treated as a plain make: key_code=0x1C, key_ext=0, press_cnt=1.
